// File: rtl/button_digit_entry_pkg.sv
// Shared constants for the pushbutton digit editor: BCD limits, button indices,
// action priority and the BCD wrap helpers.
package button_digit_entry_pkg;

    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam int unsigned NUM_BTNS = 5;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_L = 3;
    localparam int unsigned BTN_R = 4;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_COMMIT,
        ACT_INC,
        ACT_DEC,
        ACT_LEFT,
        ACT_RIGHT
    } action_e;

    // Highest-priority press wins; simultaneous lower-priority presses are dropped.
    function automatic action_e pick_action(input logic [NUM_BTNS-1:0] press);
        if (press[BTN_C]) return ACT_COMMIT;
        if (press[BTN_U]) return ACT_INC;
        if (press[BTN_D]) return ACT_DEC;
        if (press[BTN_L]) return ACT_LEFT;
        if (press[BTN_R]) return ACT_RIGHT;
        return ACT_NONE;
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton: 2-flop synchronizer, stable-count debouncer and a
// single-cycle press pulse on each accepted rising level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            // Any agreeing cycle restarts the count, so short glitches never accumulate.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/button_digit_entry.sv
// Five debounced pushbuttons editing an NUM_DIGITS-digit BCD value with a cursor;
// btnC snapshots the live value into committed with a one-cycle valid pulse.
module button_digit_entry
    import button_digit_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned NUM_DIGITS      = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          btnU,
    input  logic                                          btnD,
    input  logic                                          btnL,
    input  logic                                          btnR,
    input  logic                                          btnC,
    output logic [4*NUM_DIGITS-1:0]                       digits,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cursor,
    output logic [4*NUM_DIGITS-1:0]                       committed,
    output logic                                          commit_valid
);

    localparam int unsigned       CUR_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CUR_W-1:0]  CUR_MAX = CUR_W'(NUM_DIGITS - 1);

    logic [NUM_BTNS-1:0]         w_btn_raw;
    logic [NUM_BTNS-1:0]         w_press;
    action_e                     w_action;

    logic [NUM_DIGITS-1:0][3:0]  r_digits;
    logic [NUM_DIGITS-1:0][3:0]  r_committed;
    logic [CUR_W-1:0]            r_cursor;
    logic                        r_commit_valid;

    always_comb begin
        w_btn_raw        = '0;
        w_btn_raw[BTN_C] = btnC;
        w_btn_raw[BTN_U] = btnU;
        w_btn_raw[BTN_D] = btnD;
        w_btn_raw[BTN_L] = btnL;
        w_btn_raw[BTN_R] = btnR;
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .i_clk  (clk),
            .i_reset(reset),
            .i_btn  (w_btn_raw[g]),
            .o_press(w_press[g])
        );
    end

    always_comb w_action = pick_action(w_press);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits       <= '0;
            r_committed    <= '0;
            r_cursor       <= '0;
            r_commit_valid <= 1'b0;
        end else begin
            r_commit_valid <= 1'b0;
            case (w_action)
                ACT_COMMIT: begin
                    r_committed    <= r_digits;
                    r_commit_valid <= 1'b1;
                end
                ACT_INC:   r_digits[r_cursor] <= bcd_inc(r_digits[r_cursor]);
                ACT_DEC:   r_digits[r_cursor] <= bcd_dec(r_digits[r_cursor]);
                ACT_LEFT:  r_cursor <= (r_cursor == CUR_MAX) ? '0 : r_cursor + 1'b1;
                ACT_RIGHT: r_cursor <= (r_cursor == '0) ? CUR_MAX : r_cursor - 1'b1;
                default:   ;
            endcase
        end
    end

    assign digits       = r_digits;
    assign committed    = r_committed;
    assign cursor       = r_cursor;
    assign commit_valid = r_commit_valid;

endmodule

// File: tb/tb_button_digit_entry.sv
// Randomized bench for button_digit_entry: pin activity is scheduled against a
// digit/cursor model that applies each accepted press DEBOUNCE_CYCLES+3 edges later.
module tb_button_digit_entry;

    localparam int N    = 4;
    localparam int ND   = 8;
    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
    logic [31:0] digits;
    logic [31:0] committed;
    logic [2:0]  cursor;
    logic        commit_valid;

    always #5 clk = ~clk;

    button_digit_entry #(
        .DEBOUNCE_CYCLES(N),
        .NUM_DIGITS     (ND)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btnU        (btnU),
        .btnD        (btnD),
        .btnL        (btnL),
        .btnR        (btnR),
        .btnC        (btnC),
        .digits      (digits),
        .cursor      (cursor),
        .committed   (committed),
        .commit_valid(commit_valid)
    );

    // Mask bits: 0=C 1=U 2=D 3=L 4=R
    localparam logic [4:0] M_C = 5'b00001;
    localparam logic [4:0] M_U = 5'b00010;
    localparam logic [4:0] M_D = 5'b00100;
    localparam logic [4:0] M_L = 5'b01000;
    localparam logic [4:0] M_R = 5'b10000;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [4:0]  sched [MAXC];
    int          m_dig [ND];
    int          m_cur = 0;
    logic [31:0] m_comm = '0;
    logic        m_cv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'(m_dig[i]);
        return v;
    endfunction

    // Reference model: advances once per edge using the press schedule.
    always @(posedge clk) begin
        logic [4:0] p;
        cyc++;
        if (reset) begin
            for (int i = 0; i < ND; i++) m_dig[i] = 0;
            m_cur  = 0;
            m_comm = '0;
            m_cv   = 1'b0;
            for (int i = cyc; i < MAXC; i++) sched[i] = '0;
        end else begin
            p    = (cyc < MAXC) ? sched[cyc] : 5'b0;
            m_cv = 1'b0;
            if (p[0]) begin
                m_comm = m_pack();
                m_cv   = 1'b1;
            end else if (p[1]) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
            else if (p[2])     m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
            else if (p[3])     m_cur = (m_cur + 1) % ND;
            else if (p[4])     m_cur = (m_cur + ND - 1) % ND;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("digits", digits, m_pack());
            check("cursor", {29'b0, cursor}, m_cur);
            check("committed", committed, m_comm);
            check("commit_valid", {31'b0, commit_valid}, {31'b0, m_cv});
        end
    end

    task automatic set_pins(input logic [4:0] m);
        btnC = m[0];
        btnU = m[1];
        btnD = m[2];
        btnL = m[3];
        btnR = m[4];
    endtask

    task automatic next_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sched_add(input int at, input logic [4:0] m);
        if (at >= MAXC) begin
            $display("FAIL schedule: edge %0d beyond model horizon %0d", at, MAXC);
            $fatal(1);
        end
        sched[at] = sched[at] | m;
    endtask

    // Called #1 after an edge: the pin change is first sampled at edge cyc+1.
    task automatic press(input logic [4:0] m, input int hold);
        set_pins(m);
        sched_add(cyc + N + 4, m);
        next_edge(hold);
        set_pins('0);
        next_edge(N + 4);
    endtask

    task automatic glitch(input logic [4:0] m, input int len);
        set_pins(m);
        next_edge(len);
        set_pins('0);
        next_edge(3);
    endtask

    task automatic mid_reset(input logic [4:0] m);
        set_pins(m);
        next_edge(2);
        reset = 1'b1;
        next_edge(2);
        reset = 1'b0;
        sched_add(cyc + N + 4, m);
        next_edge(10);
        set_pins('0);
        next_edge(N + 4);
    endtask

    initial begin
        logic [4:0] m;
        int a, b;
        for (int i = 0; i < MAXC; i++) sched[i] = '0;
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        set_pins('0);
        next_edge(3);
        check("rst_digits", digits, 32'h0);
        check("rst_cursor", {29'b0, cursor}, 32'd0);
        check("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
        reset = 1'b0;
        next_edge(1);

        press(M_U, 10);
        check("t1_digits", digits, 32'h0000_0001);

        for (int r = 0; r < 2; r++)
            for (int len = 1; len < N; len++) glitch(M_U, len);
        check("t2_digits", digits, 32'h0000_0001);

        for (int i = 0; i < 9; i++) press(M_U, N + 2);
        check("t3_wrap_up", digits, 32'h0000_0000);
        press(M_D, N + 3);
        check("t3_wrap_down", digits, 32'h0000_0009);

        for (int i = 0; i < ND; i++) press(M_L, N + 2);
        check("t4_cursor_wrap", {29'b0, cursor}, 32'd0);
        press(M_R, N + 2);
        check("t4_cursor_r", {29'b0, cursor}, 32'd7);
        press(M_U, N + 2);
        check("t4_msd", digits, 32'h1000_0009);

        press(M_C | M_U, 8);
        check("t5_committed", committed, 32'h1000_0009);
        check("t5_digits", digits, 32'h1000_0009);

        mid_reset(M_C);
        check("t6_digits", digits, 32'h0);
        check("t6_committed", committed, 32'h0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    m = 5'b1 << $urandom_range(0, 4);
                    press(m, $urandom_range(N + 2, N + 8));
                end
                6: begin
                    m = 5'b1 << $urandom_range(0, 4);
                    glitch(m, $urandom_range(1, N - 1));
                end
                7: begin
                    a = $urandom_range(0, 4);
                    b = $urandom_range(0, 4);
                    m = (5'b1 << a) | (5'b1 << b);
                    press(m, $urandom_range(N + 2, N + 8));
                end
                8: press(M_C, $urandom_range(N + 2, N + 8));
                default: begin
                    m = 5'b1 << $urandom_range(0, 4);
                    mid_reset(m);
                end
            endcase
        end

        next_edge(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
